// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial add controller. A single one-bit full-adder slice is reused for
// every bit position. Operands are captured on an accepted start, then walked
// LSB-to-MSB one bit per clock. The registered sum and carry-out update only
// on the completion edge. done pulses for one cycle after that edge.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, a 'sub' input selects op_a - op_b. B is inverted and the
//   carry is forced to 1 (two's complement), so cout=1 means no borrow.
//
// Parameters:
//   WIDTH   operand/result width, 2..32
//
// Ports:
//   clk     clock, rising edge
//   rst_n   asynchronous active-low reset
//   start   request, sampled only in IDLE
//   op_a    operand A, captured on accepted start
//   op_b    operand B, captured on accepted start
//   cin     carry-in, captured on accepted start
//   sub     subtract select (only with SERIAL_ADDER_SUB_EN)
//   busy    high while the bits are being walked
//   done    one-cycle completion pulse
//   result  registered sum
//   cout    registered carry-out of bit WIDTH-1
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
    logic             c_q;
    logic [CW-1:0]    cnt;

    // Subtract select as seen by the load path; constant 0 in add-only builds.
    logic sub_sel;
`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    // Shared one-bit full-adder slice.
    logic s_bit, c_nxt;
    assign s_bit = a_sr[0] ^ b_sr[0] ^ c_q;
    assign c_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & c_q) | (b_sr[0] & c_q);

    logic last_bit;
    assign last_bit = (cnt == LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last_bit) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // busy/done decode straight from the state register, so an async reset
    // drops them immediately and they can never be high together.
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            c_q    <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= op_a;
                        b_sr   <= sub_sel ? ~op_b : op_b;
                        c_q    <= sub_sel ? 1'b1 : cin;
                        sum_sr <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    c_q    <= c_nxt;
                    sum_sr <= {s_bit, sum_sr[WIDTH-1:1]};
                    // Counter parks at WIDTH-1 on the last bit instead of wrapping.
                    if (!last_bit) cnt <= cnt + 1'b1;
                    if (last_bit) begin
                        result <= {s_bit, sum_sr[WIDTH-1:1]};
                        cout   <= c_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] result;

    int total = 0;
    int bad   = 0;

    // Scoreboard of expected {cout, result}
    logic [W:0] sb_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .cin    (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub    (sub),
`endif
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request at the current negedge; returns at the negedge after
    // the accepting edge with start dropped.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb);
        logic [W:0] e;
        op_a  = a;
        op_b  = b;
        cin   = ci;
        sub   = sb;
        start = 1'b1;
        if (sb) e = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else    e = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done, check result against scoreboard, busy count,
    // exclusivity and the single-cycle pulse.
    task automatic finish_op(input string tag, input int exp_busy);
        int   nb   = 0;
        bit   seen = 0;
        bit   ov   = 0;
        logic [W:0] e;
        for (int i = 0; i < 4*W + 8 && !seen; i++) begin
            if (busy && done) ov = 1;
            if (done) seen = 1;
            else begin
                if (busy) nb++;
                @(negedge clk);
            end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_busy_done_excl"}, 64'(ov), 64'd0);
        if (seen) begin
            e = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
            chk({tag, "_result"}, 64'(result), 64'(e[W-1:0]));
            chk({tag, "_cout"}, 64'(cout), 64'(e[W]));
            chk({tag, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
            @(negedge clk);
            chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        int cyc, last_done, ndone;
        bit extra;

        // Reset state
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add and carry chain
        launch(8'h35, 8'h4A, 1'b0, 1'b0);
        chk("basic_busy_after_accept", 64'(busy), 64'd1);
        finish_op("basic", W);
        launch(8'hFF, 8'h01, 1'b0, 1'b0); finish_op("ff_p_01", W);
        launch(8'hFF, 8'hFF, 1'b1, 1'b0); finish_op("ff_p_ff_c", W);
        launch(8'h00, 8'h00, 1'b1, 1'b0); finish_op("zero_c", W);

        // Start during RUN is ignored
        launch(8'h10, 8'h20, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        op_a = 8'hAA; op_b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_op("ign_start", W - 4);
        extra = 0;
        for (int i = 0; i < 2*W + 4; i++) begin
            if (done) extra = 1;
            @(negedge clk);
        end
        chk("ign_no_2nd_done", 64'(extra), 64'd0);

        // Reset mid-operation
        launch(8'h77, 8'h11, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(sb_q.pop_back());
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch(8'h01, 8'h02, 1'b0, 1'b0); finish_op("post_rst", W);

        // Back-to-back with start held high
        op_a = 8'h0F; op_b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
        repeat (3) sb_q.push_back({1'b0, 8'h10});
        cyc = 0; last_done = -1; ndone = 0;
        for (int i = 0; i < 200 && ndone < 3; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                logic [W:0] e;
                e = sb_q.pop_front();
                chk("b2b_result", 64'(result), 64'(e[W-1:0]));
                chk("b2b_cout", 64'(cout), 64'(e[W]));
                if (last_done >= 0) chk("b2b_period", 64'(cyc - last_done), 64'(W + 2));
                last_done = cyc;
                ndone++;
                if (ndone == 3) start = 1'b0;
            end
        end
        chk("b2b_three_dones", 64'(ndone), 64'd3);
        repeat (2) @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        launch(8'h10, 8'h01, 1'b0, 1'b1); finish_op("sub_10_01", W);
        launch(8'h01, 8'h02, 1'b1, 1'b1); finish_op("sub_01_02", W);
`endif

        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
